voice_ram_sched: RTL and testbench
==================================

VOICE_RAM_SCHED -- requirements
Module: voice_ram_sched

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter NUM_VOICES, default 16, voice slots swept per sample; legal range 1..2**ADDR_W.
REQ-004 Parameter VOICE_BASE, default 0, RAM address of voice 0; VOICE_BASE+NUM_VOICES <= 2**ADDR_W.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 sample_tick  in  1  one-cycle pulse requesting a full voice sweep.
REQ-008 host_req / host_we  in  1 / 1  MIDI-side access request / write qualifier; held with addr/wdata until host_ack.
REQ-009 host_addr / host_wdata  in  ADDR_W / DATA_W  host access address / write data.
REQ-010 host_ack  out  1  registered one-cycle completion pulse.
REQ-011 host_rdata  out  DATA_W  registered read data, valid with host_ack, held until next host access.
REQ-012 ram_addr / ram_din / ram_we  out  ADDR_W / DATA_W / 1  drive to the shared single-port RAM.
REQ-013 ram_dout  in  DATA_W  RAM asynchronous read data.
REQ-014 voice_valid / voice_idx / voice_data  out  1 / ADDR_W / DATA_W  voice state offered to synth datapath.
REQ-015 upd_valid / upd_data  in  1 / DATA_W  updated voice state returned by datapath.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, HOST, READ, WAIT_UPD, WRITE; exactly one RAM master per cycle.
REQ-018 ram_we SHALL be high only in WRITE (ram_din=upd capture, ram_addr=VOICE_BASE+idx) and in HOST with host_we=1.
REQ-019 IDLE: host_req has priority over a pending tick -> HOST; else pending tick -> READ with idx=0; else stay.
REQ-020 HOST: one cycle, RAM driven from host_addr/host_wdata/host_we; host_rdata<=ram_dout and host_ack=1 next cycle; return to the state saved on entry (IDLE or READ).
REQ-021 host_req SHALL be ignored in the cycle host_ack is high (no double service).
REQ-022 READ: ram_addr=VOICE_BASE+idx; voice_data<=ram_dout, voice_idx<=idx; -> WAIT_UPD.
REQ-023 WAIT_UPD: voice_valid=1; stay until upd_valid; on upd_valid capture upd_data -> WRITE. upd_valid outside WAIT_UPD SHALL be ignored.
REQ-024 WRITE: write back; if idx=NUM_VOICES-1 -> IDLE, idx<=0, else idx<=idx+1 and -> HOST if host_req pending (return READ), else READ.
REQ-025 At most one host access between consecutive voice slots; minimum 3 cycles per voice.
REQ-026 sample_tick SHALL set a one-deep tick_pending flag, cleared on sweep start; tick coincident with sweep start from IDLE is consumed by that start.
REQ-027 Address arithmetic VOICE_BASE+idx SHALL be ADDR_W wide; no wrap occurs given REQ-004.

Reset
REQ-028 On rst_n low, immediately: state=IDLE, idx=0, tick_pending=0, host_ack=0, host_rdata=0, voice_data=0, voice_idx=0, ram_we=0, busy=0, overrun=0.
REQ-029 Reset mid-sweep or mid-HOST SHALL abandon the access; no partial write after reset release.

Configuration
REQ-030 Macro VOICE_RAM_SCHED_OVERRUN_EN: when defined, output overrun (1 bit) is a sticky flag set when sample_tick arrives while tick_pending=1 or while a sweep is already running with tick_pending=1, cleared only by reset.
REQ-031 Without the macro, overrun port is absent and extra ticks are silently merged into tick_pending.

Structure
REQ-032 Shared package voice_ram_pkg SHALL hold the FSM state encoding and default parameter constants.
REQ-033 No sub-module; RAM instantiated by parent and connected via ram_* ports.

Verification
REQ-034 Reset, tick, upd_valid one cycle after each voice_valid -> 16 voices, idx 0..15, each RAM word = upd_data, busy low after 48 cycles.
REQ-035 host_req write addr 0x40 data 0xA5 in IDLE -> host_ack 2 cycles later; host read 0x40 -> host_rdata=0xA5.
REQ-036 host_req held throughout sweep -> exactly one HOST between voice 3 and 4 etc., never two consecutive, no double ack.
REQ-037 Tick twice during sweep with overrun macro -> overrun=1, one extra sweep follows; without macro -> one extra sweep, no port.
REQ-038 rst_n low in WAIT_UPD of voice 5 -> outputs reset values same cycle, RAM word 5 unchanged.

Source files
------------

// File: rtl/voice_ram_pkg.sv
// Shared definitions for the voice RAM scheduler: FSM state encoding and
// default parameter values.
package voice_ram_pkg;

  localparam int unsigned DEF_ADDR_W     = 8;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_NUM_VOICES = 16;
  localparam int unsigned DEF_VOICE_BASE = 0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOST     = 3'd1,
    READ     = 3'd2,
    WAIT_UPD = 3'd3,
    WRITE    = 3'd4
  } vr_state_t;

endpackage

// File: rtl/voice_ram_sched.sv
// Voice RAM scheduler: arbitrates one shared single-port RAM between the
// MIDI host port and a per-sample sweep over all voice slots
// (read -> datapath update -> write back).
// Optional feature macro: VOICE_RAM_SCHED_OVERRUN_EN adds the sticky
// 'overrun' output flagging sample ticks that arrive while one is
// already pending.
module voice_ram_sched
  import voice_ram_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned NUM_VOICES = DEF_NUM_VOICES,
  parameter int unsigned VOICE_BASE = DEF_VOICE_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              voice_valid,
  output logic [ADDR_W-1:0] voice_idx,
  output logic [DATA_W-1:0] voice_data,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_data,
  output logic              busy
`ifdef VOICE_RAM_SCHED_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(VOICE_BASE);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_VOICES - 1);

  vr_state_t         state;
  vr_state_t         ret_state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] upd_q;
  logic              tick_pending;
  logic [ADDR_W-1:0] voice_addr;

  assign voice_addr = BASE_ADDR + idx;

  // RAM master select: host port only in HOST, otherwise the sweep slot.
  always_comb begin
    ram_addr = voice_addr;
    ram_din  = upd_q;
    ram_we   = 1'b0;
    if (state == HOST) begin
      ram_addr = host_addr;
      ram_din  = host_wdata;
      ram_we   = host_we;
    end else if (state == WRITE) begin
      ram_we   = 1'b1;
    end
  end

  // Scheduler FSM with registered outputs and tick bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ret_state    <= IDLE;
      idx          <= '0;
      upd_q        <= '0;
      tick_pending <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      voice_valid  <= 1'b0;
      voice_idx    <= '0;
      voice_data   <= '0;
      busy         <= 1'b0;
`ifdef VOICE_RAM_SCHED_OVERRUN_EN
      overrun      <= 1'b0;
`endif
    end else begin
      host_ack <= 1'b0;
      if (sample_tick) tick_pending <= 1'b1;
`ifdef VOICE_RAM_SCHED_OVERRUN_EN
      if (sample_tick && tick_pending) overrun <= 1'b1;
`endif
      case (state)
        IDLE: begin
          // The ack cycle still sees the completed request held high.
          if (host_req && !host_ack) begin
            state     <= HOST;
            ret_state <= IDLE;
            busy      <= 1'b1;
          end else if (tick_pending || sample_tick) begin
            // A tick arriving in this very cycle is consumed by this start.
            state        <= READ;
            idx          <= '0;
            tick_pending <= 1'b0;
            busy         <= 1'b1;
          end
        end
        HOST: begin
          host_rdata <= ram_dout;
          host_ack   <= 1'b1;
          state      <= ret_state;
          busy       <= (ret_state != IDLE);
        end
        READ: begin
          voice_data  <= ram_dout;
          voice_idx   <= idx;
          voice_valid <= 1'b1;
          state       <= WAIT_UPD;
        end
        WAIT_UPD: begin
          if (upd_valid) begin
            upd_q       <= upd_data;
            voice_valid <= 1'b0;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + ADDR_W'(1);
            if (host_req) begin
              state     <= HOST;
              ret_state <= READ;
            end else begin
              state <= READ;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_ram_sched.sv
// Self-checking bench for voice_ram_sched: RAM model, datapath responder
// and a write-back scoreboard queue.
module tb_voice_ram_sched;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NV = 16;
  localparam int VB = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic          voice_valid;
  logic [AW-1:0] voice_idx;
  logic [DW-1:0] voice_data;
  logic          upd_valid = 1'b0;
  logic [DW-1:0] upd_data = '0;
  logic          busy;
`ifdef VOICE_RAM_SCHED_OVERRUN_EN
  logic          overrun;
`endif

  always #5 clk = ~clk;

  voice_ram_sched #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_VOICES(NV), .VOICE_BASE(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .voice_valid(voice_valid), .voice_idx(voice_idx), .voice_data(voice_data),
    .upd_valid(upd_valid), .upd_data(upd_data), .busy(busy)
`ifdef VOICE_RAM_SCHED_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  function automatic logic [7:0] seed(input int i);
    return 8'((i * 37 + 11) ^ 90);
  endfunction

  // Single-port RAM model with asynchronous read.
  logic [DW-1:0] mem [0:255];
  logic          ram_init = 1'b0;
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end

  int            n_chk = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_mem [0:255];
  logic [15:0]   wr_q [$];
  int            exp_idx = 0;
  int            voices = 0;
  int            busy_cyc = 0;
  int            acks = 0;
  int            consec = 0;
  bit            prev_ack = 1'b0;
  bit            vv_seen = 1'b0;
  bit            stall_on = 1'b0;
  int            stall_idx = 0;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task wait_idle(input int budget, input string tag);
    int t;
    t = 0;
    while (busy && t < budget) begin
      cyc(1);
      t++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task host_access(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                   output logic [7:0] rd, output int lat);
    int t;
    if (we) begin
      wr_q.push_back({addr, wd});
      exp_mem[addr] = wd;
    end
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    t = 0;
    do begin
      cyc(1);
      t++;
    end while (!host_ack && t < 50);
    check("h_ack_seen", host_ack, 1);
    lat = t;
    rd  = host_rdata;
    cyc(1);
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task sweep_words(input string tag);
    int nb;
    nb = 0;
    for (int i = 0; i < NV; i++) if (mem[VB + i] !== exp_mem[VB + i]) nb++;
    check(tag, nb, 0);
  endtask

  // Negedge monitor: counters, write-back scoreboard, datapath responder.
  task bg_loop();
    logic [15:0] e;
    logic [7:0]  d;
    logic [7:0]  a;
    forever begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (host_ack) begin
        acks++;
        if (prev_ack) consec++;
      end
      prev_ack = host_ack;
      if (rst_n && ram_we) begin
        if (wr_q.size() == 0) check("wr_expected", wr_q.size(), 1);
        else begin
          e = wr_q.pop_front();
          check("wr_addr", ram_addr, e[15:8]);
          check("wr_data", ram_din, e[7:0]);
        end
      end
      if (upd_valid) upd_valid = 1'b0;
      else if (voice_valid && !vv_seen) begin
        a = 8'(VB + exp_idx);
        check("voice_idx", voice_idx, exp_idx);
        check("voice_data", voice_data, exp_mem[a]);
        voices++;
        if (!(stall_on && exp_idx == stall_idx)) begin
          d = 8'($urandom);
          upd_data  = d;
          upd_valid = 1'b1;
          wr_q.push_back({a, d});
          exp_mem[a] = d;
        end
        exp_idx = (exp_idx == NV - 1) ? 0 : exp_idx + 1;
        vv_seen = 1'b1;
      end
      if (!voice_valid) vv_seen = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int lat, a0, v0, t;
    fork
      bg_loop();
    join_none

    rst_n = 1'b0;
    ram_init = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = seed(i);
    cyc(1);
    ram_init = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_ack", host_ack, 0);
    check("rst_rdata", host_rdata, 0);
    check("rst_vvalid", voice_valid, 0);
    check("rst_vidx", voice_idx, 0);
    check("rst_vdata", voice_data, 0);
    check("rst_we", ram_we, 0);
`ifdef VOICE_RAM_SCHED_OVERRUN_EN
    check("rst_overrun", overrun, 0);
`endif
    rst_n = 1'b1;
    cyc(2);

    // Full sweep, 3 cycles per voice.
    busy_cyc = 0; v0 = voices;
    sample_tick = 1'b1; cyc(1); sample_tick = 1'b0;
    wait_idle(200, "s1");
    check("s1_busy_cyc", busy_cyc, 48);
    check("s1_voices", voices - v0, 16);
    check("s1_wq_empty", wr_q.size(), 0);
    sweep_words("s1_ram");

    // Host write then read in IDLE; ack held request must not re-trigger.
    a0 = acks;
    host_access(1'b1, 8'h40, 8'hA5, rd, lat);
    check("h_wr_lat", lat, 2);
    check("h_wr_rdata_old", rd, seed(8'h40));
    host_access(1'b0, 8'h40, 8'h00, rd, lat);
    check("h_rd_lat", lat, 2);
    check("h_rd_data", rd, 8'hA5);
    cyc(4);
    check("h_ack_count", acks - a0, 2);
    check("h_rdata_held", host_rdata, 8'hA5);
    check("h_mem40", mem[8'h40], exp_mem[8'h40]);

    // Host request held across a sweep: one access per voice gap.
    a0 = acks; busy_cyc = 0; v0 = voices;
    sample_tick = 1'b1; cyc(1); sample_tick = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    wait_idle(400, "s2");
    host_req = 1'b0;
    check("s2_busy_cyc", busy_cyc, 63);
    check("s2_acks", acks - a0, 15);
    check("s2_voices", voices - v0, 16);
    check("s2_rdata", host_rdata, 8'hA5);
    check("ack_consec", consec, 0);
    sweep_words("s2_ram");
    cyc(3);

    // Two extra ticks during a sweep merge into one extra sweep.
    busy_cyc = 0; v0 = voices;
    sample_tick = 1'b1; cyc(1); sample_tick = 1'b0;
    cyc(10);
    sample_tick = 1'b1; cyc(1); sample_tick = 1'b0;
`ifdef VOICE_RAM_SCHED_OVERRUN_EN
    check("ovr_after_one", overrun, 0);
`endif
    cyc(10);
    sample_tick = 1'b1; cyc(1); sample_tick = 1'b0;
`ifdef VOICE_RAM_SCHED_OVERRUN_EN
    check("ovr_after_two", overrun, 1);
`endif
    t = 0;
    while (!((voices - v0) == 32 && !busy) && t < 400) begin
      cyc(1);
      t++;
    end
    check("s3_done", (t < 400), 1);
    cyc(20);
    check("s3_voices", voices - v0, 32);
    check("s3_busy_cyc", busy_cyc, 96);
    check("s3_idle", busy, 0);
    sweep_words("s3_ram");

    // Reset while voice 5 waits for its update.
    stall_on = 1'b1; stall_idx = 5;
    sample_tick = 1'b1; cyc(1); sample_tick = 1'b0;
    t = 0;
    while (!(voice_valid && voice_idx == 8'd5) && t < 100) begin
      cyc(1);
      t++;
    end
    check("r_reach_v5", (t < 100), 1);
    cyc(3);
    rst_n = 1'b0;
    #1;
    check("r_busy", busy, 0);
    check("r_vvalid", voice_valid, 0);
    check("r_vidx", voice_idx, 0);
    check("r_vdata", voice_data, 0);
    check("r_we", ram_we, 0);
    check("r_ack", host_ack, 0);
    check("r_rdata", host_rdata, 0);
`ifdef VOICE_RAM_SCHED_OVERRUN_EN
    check("r_overrun", overrun, 0);
`endif
    cyc(2);
    exp_idx = 0; stall_on = 1'b0;
    rst_n = 1'b1;
    cyc(5);
    check("r_mem5", mem[VB + 5], exp_mem[VB + 5]);
    check("r_wq_empty", wr_q.size(), 0);
    check("r_idle", busy, 0);

    // Sweep after reset restarts from voice 0.
    busy_cyc = 0; v0 = voices;
    sample_tick = 1'b1; cyc(1); sample_tick = 1'b0;
    wait_idle(200, "s4");
    check("s4_busy_cyc", busy_cyc, 48);
    check("s4_voices", voices - v0, 16);
    sweep_words("s4_ram");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
